mod_147_rx_align: RTL
=====================

MOD_147_RX_ALIGN -- requirements
Module: mod_147_rx_align

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` and `pcs_reset`.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- `clk`  in  1  PCS clock; all state updates on its rising edge.
- `pcs_reset`  in  1  synchronous active-high reset; highest priority.
- `pma_rx_bit_valid`  in  1  one-cycle strobe per recovered bit (PMA_UNITDATA.indication).
- `pma_rx_bit`  in  1  recovered bit, sampled only when `pma_rx_bit_valid`=1.
- `rx_silence`  in  1  level; PMA reports no carrier.
- `RXn`  out  5  newest aligned code-group.
- `RXn_1`  out  5  previous code-group.
- `RXn_2`  out  5  code-group two back.
- `RXn_3`  out  5  code-group three back.
- `RSCD`  out  1  one-cycle pulse; new code-group is on `RXn` this cycle.
- `align_state`  out  2  00=SILENT, 01=HUNT, 10=LOCKED.

Function
REQ-003 The block SHALL use the clause-147 parameter set for these constants: SYNC=5'b11000 (J), and SILENCE.
REQ-004 The first received bit of a code-group SHALL be its MSB; the shift register SHALL shift left with the new bit entering the LSB.
REQ-005 On each `RSCD` pulse, the taps SHALL shift together: `RXn_3`<=`RXn_2`, `RXn_2`<=`RXn_1`, `RXn_1`<=`RXn`, `RXn`<=new code-group.
- The taps SHALL hold their values when `RSCD` is not pulsing.
REQ-006 `RSCD` and the updated `RXn` SHALL appear in the cycle after the strobe that completes the code-group (latency of 1 clock).
REQ-007 `RSCD` SHALL never be high for two consecutive cycles.
REQ-008 SILENT state:
- A 3-bit bit counter SHALL count strobes 0..4.
- On the strobe at count 4, the block SHALL emit `RXn`=SILENCE with `RSCD`, and the counter SHALL wrap to 0.
REQ-009 SILENT SHALL go to HUNT in the cycle after `rx_silence` is sampled low; the shift register SHALL clear to 5'b00000 on HUNT entry.
REQ-010 HUNT state:
- Each strobe SHALL shift in one bit.
- No `RSCD` SHALL be produced.
- When the post-shift window equals SYNC, the block SHALL emit SYNC with `RSCD`, go to LOCKED and set the bit counter to 0.
REQ-011 LOCKED state:
- Each strobe SHALL shift in one bit.
- On the strobe at count 4, the block SHALL emit the 5-bit window with `RSCD`, and the counter SHALL wrap to 0.
REQ-012 Invalid code-groups SHALL be: 00000, 00001, 00010, 00011, 00101, 00110, 01000, 01100, 10000, 11001.
REQ-013 A 2-bit error counter SHALL increment on each emitted invalid code-group and clear on each emitted valid code-group.
REQ-014 On the third consecutive invalid code-group, the block SHALL still emit that code-group with `RSCD`, then go to HUNT, clearing the error counter and the shift register.
REQ-015 `rx_silence`=1 in HUNT or LOCKED SHALL force SILENT on the next edge:
- any partial code-group SHALL be discarded;
- the bit counter and error counter SHALL clear;
- no `RSCD` SHALL be produced that cycle.
REQ-016 Priority SHALL be: `pcs_reset` > `rx_silence` > error-driven loss of lock > normal symbol assembly.
REQ-017 If a strobe coincides with `rx_silence`=1 while in LOCKED, the bit SHALL be discarded.
REQ-018 The bit counter SHALL advance only on `pma_rx_bit_valid`=1; with no strobe, all state SHALL hold.

Reset
REQ-019 While `pcs_reset`=1 at a clock edge, the block SHALL set:
- `align_state`=SILENT;
- `RXn`, `RXn_1`, `RXn_2`, `RXn_3` = SILENCE;
- `RSCD`=0;
- shift register = 0, bit counter = 0, error counter = 0.
REQ-020 Reset SHALL take effect from any state, including mid-code-group, on the same edge; no symbol SHALL be emitted in that cycle.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset: assert `pcs_reset` 2 cycles -> all taps = SILENCE, `RSCD`=0, `align_state`=00.
- Lock: `rx_silence`=0, then bits 0,1,1,0,0,0 -> one cycle after the 6th strobe, `RSCD`=1, `RXn`=11000, `align_state`=10.
- Pipeline: locked; code-groups J, J, K(10001), 11110 -> `RXn`=11110, `RXn_1`=10001, `RXn_2`=11000, `RXn_3`=11000; exactly 4 `RSCD` pulses.
- Error count: locked; three code-groups 00001 -> three `RSCD` pulses with `RXn`=00001, then `align_state`=01. Repeat with 00001, 00001, 11110 -> remains 10.
- Silence: locked; `rx_silence`=1 after 2 bits of a code-group -> next cycle `align_state`=00 with no `RSCD`. After 20 further strobes, exactly 4 `RSCD` pulses and `RXn_3`=SILENCE.
- Mid-symbol reset: locked, 3 bits into a code-group; assert `pcs_reset` -> next cycle reset values, with no `RSCD`.

Source files
------------

// File: rtl/mod_147_rx_align.sv
// ---------------------------------------------------------------------------
// mod_147_rx_align
//
// Receive code-group alignment for a 4B/5B PCS receive path. Serial bits
// recovered by the PMA are assembled into 5-bit code-groups. While the PMA
// reports no carrier the block emits SILENCE code-groups at the symbol rate.
// Once carrier is present it hunts for the SYNC (J) code-group to find the
// symbol boundary, and then emits every 5-bit window on that boundary. Three
// invalid code-groups in a row drop the block back to hunting.
//
// Ports:
//   clk               PCS clock, rising-edge active
//   pcs_reset         synchronous active-high reset, highest priority
//   pma_rx_bit_valid  one-cycle strobe per recovered bit
//   pma_rx_bit        recovered bit, used only while the strobe is high
//   rx_silence        level, PMA reports no carrier
//   RXn               newest aligned code-group
//   RXn_1             previous code-group
//   RXn_2             code-group two back
//   RXn_3             code-group three back
//   RSCD              one-cycle pulse, a new code-group is on RXn
//   align_state       00 = SILENT, 01 = HUNT, 10 = LOCKED
// ---------------------------------------------------------------------------
module mod_147_rx_align (
    input  logic       clk,
    input  logic       pcs_reset,
    input  logic       pma_rx_bit_valid,
    input  logic       pma_rx_bit,
    input  logic       rx_silence,
    output logic [4:0] RXn,
    output logic [4:0] RXn_1,
    output logic [4:0] RXn_2,
    output logic [4:0] RXn_3,
    output logic       RSCD,
    output logic [1:0] align_state
);

    localparam logic [1:0] ST_SILENT = 2'b00;
    localparam logic [1:0] ST_HUNT   = 2'b01;
    localparam logic [1:0] ST_LOCKED = 2'b10;

    localparam logic [4:0] SYNC    = 5'b11000;
    localparam logic [4:0] SILENCE = 5'b11111;

    logic [1:0] state_q,   state_d;
    logic [4:0] shift_q,   shift_d;
    logic [2:0] bitCnt_q,  bitCnt_d;
    logic [1:0] errCnt_q,  errCnt_d;
    logic [4:0] rxn0_q, rxn1_q, rxn2_q, rxn3_q;
    logic       rscd_q;

    logic       emit;
    logic [4:0] emitGroup;
    logic [4:0] window;

    // Code-groups that carry no meaning in the 4B/5B table.
    function automatic logic isInvalid(input logic [4:0] g);
        case (g)
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00101,
            5'b00110, 5'b01000, 5'b01100, 5'b10000, 5'b11001: isInvalid = 1'b1;
            default:                                          isInvalid = 1'b0;
        endcase
    endfunction

    // First received bit ends up as the MSB: shift left, new bit in the LSB.
    assign window = {shift_q[3:0], pma_rx_bit};

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitCnt_d  = bitCnt_q;
        errCnt_d  = errCnt_q;
        emit      = 1'b0;
        emitGroup = SILENCE;

        case (state_q)
            ST_SILENT: begin
                // Keep the symbol clock ticking with SILENCE code-groups.
                if (pma_rx_bit_valid) begin
                    if (bitCnt_q == 3'd4) begin
                        emit      = 1'b1;
                        emitGroup = SILENCE;
                        bitCnt_d  = 3'd0;
                    end else begin
                        bitCnt_d  = bitCnt_q + 3'd1;
                    end
                end
                errCnt_d = 2'd0;
                if (!rx_silence) begin
                    state_d  = ST_HUNT;
                    shift_d  = 5'b00000;
                    bitCnt_d = 3'd0;
                end
            end

            ST_HUNT: begin
                if (rx_silence) begin
                    state_d  = ST_SILENT;
                    shift_d  = 5'b00000;
                    bitCnt_d = 3'd0;
                    errCnt_d = 2'd0;
                end else if (pma_rx_bit_valid) begin
                    shift_d = window;
                    // SYNC found on any bit position defines the boundary.
                    if (window == SYNC) begin
                        emit      = 1'b1;
                        emitGroup = SYNC;
                        state_d   = ST_LOCKED;
                        bitCnt_d  = 3'd0;
                        errCnt_d  = 2'd0;
                    end
                end
            end

            ST_LOCKED: begin
                // Loss of carrier wins; a coincident bit is dropped.
                if (rx_silence) begin
                    state_d  = ST_SILENT;
                    shift_d  = 5'b00000;
                    bitCnt_d = 3'd0;
                    errCnt_d = 2'd0;
                end else if (pma_rx_bit_valid) begin
                    shift_d = window;
                    if (bitCnt_q == 3'd4) begin
                        emit      = 1'b1;
                        emitGroup = window;
                        bitCnt_d  = 3'd0;
                        if (isInvalid(window)) begin
                            // Third invalid in a row: still emitted, then re-hunt.
                            if (errCnt_q == 2'd2) begin
                                state_d  = ST_HUNT;
                                errCnt_d = 2'd0;
                                shift_d  = 5'b00000;
                            end else begin
                                errCnt_d = errCnt_q + 2'd1;
                            end
                        end else begin
                            errCnt_d = 2'd0;
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d  = ST_SILENT;
                shift_d  = 5'b00000;
                bitCnt_d = 3'd0;
                errCnt_d = 2'd0;
            end
        endcase
    end

    // State, taps and the RSCD strobe; taps move only on an emitted group.
    always_ff @(posedge clk) begin
        if (pcs_reset) begin
            state_q  <= ST_SILENT;
            shift_q  <= 5'b00000;
            bitCnt_q <= 3'd0;
            errCnt_q <= 2'd0;
            rxn0_q   <= SILENCE;
            rxn1_q   <= SILENCE;
            rxn2_q   <= SILENCE;
            rxn3_q   <= SILENCE;
            rscd_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitCnt_q <= bitCnt_d;
            errCnt_q <= errCnt_d;
            rscd_q   <= emit;
            if (emit) begin
                rxn3_q <= rxn2_q;
                rxn2_q <= rxn1_q;
                rxn1_q <= rxn0_q;
                rxn0_q <= emitGroup;
            end
        end
    end

    assign RXn         = rxn0_q;
    assign RXn_1       = rxn1_q;
    assign RXn_2       = rxn2_q;
    assign RXn_3       = rxn3_q;
    assign RSCD        = rscd_q;
    assign align_state = state_q;

endmodule
